// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// It runs one operation at a time. Multiplies use shift-add and divides use
// restoring division, each on operand magnitudes over 32 cycles. Signs are
// fixed up when the result is written. Special-case divides finish on the
// accept edge.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_W   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    state_t            state, state_next;

    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              is_div_in;
    logic              a_signed_in;
    logic              b_signed_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              special_in;
    logic [XLEN-1:0]   special_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   final_result;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [2*XLEN-1:0] negate_wide(input logic [2*XLEN-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Decode the request: signedness, magnitudes and the special-case divides.
    always_comb begin
        accept      = (state == IDLE) && start && !flush;
        is_div_in   = funct3[2];
        a_signed_in = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
        b_signed_in = is_div_in ? ~funct3[0] : ~funct3[1];
        neg_a_in    = a_signed_in && op_a[XLEN-1];
        neg_b_in    = b_signed_in && op_b[XLEN-1];
        mag_a_in    = neg_a_in ? negate(op_a) : op_a;
        mag_b_in    = neg_b_in ? negate(op_b) : op_b;

        special_in     = 1'b0;
        special_result = '0;
        if (is_div_in && (op_b == '0)) begin
            special_in     = 1'b1;
            special_result = funct3[1] ? op_a : '1;
        end else if (is_div_in && !funct3[0] && (op_a == MIN_INT) && (op_b == '1)) begin
            special_in     = 1'b1;
            special_result = funct3[1] ? '0 : MIN_INT;
        end
    end

    // One iteration step, plus the sign-corrected result of the final step.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_next = div_diff[XLEN-1:0];
                lo_next = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_next = div_shift[XLEN-1:0];
                lo_next = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        product = {hi_next, lo_next};
        if (neg_a_q ^ neg_b_q) begin
            product = negate_wide(product);
        end

        final_result = '0;
        case (op_q)
            3'b000:                 final_result = product[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = product[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = (neg_a_q ^ neg_b_q) ? negate(lo_next) : lo_next;
            default:                final_result = neg_a_q ? negate(hi_next) : hi_next;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: flush wins over everything, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, load result on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            rd_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (accept) begin
            op_q    <= funct3;
            rd_q    <= rd_in;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            cnt_q   <= '0;
            hi_q    <= '0;
            if (is_div_in) begin
                opnd_q <= mag_b_in;
                lo_q   <= mag_a_in;
            end else begin
                opnd_q <= mag_a_in;
                lo_q   <= mag_b_in;
            end
            if (special_in) begin
                result <= special_result;
                rd_out <= rd_in;
            end
        end else if ((state == CALC) && !flush) begin
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                result <= final_result;
                rd_out <= rd_q;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of the RV32M multiply/divide rules.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference result computed with plain 64-bit and integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int          sa;
        int          sb;
        if (!f3[2]) begin
            ea = (f3 != 3'b011) ? {{32{a[31]}}, a} : {32'h0, a};
            eb = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
            p  = ea * eb;
            return (f3 == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'h0 : 32'h8000_0000;
        if (!f3[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Count done pulses over n cycles, sampling at falling edges.
    task automatic countDone(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    // Issue one operation from IDLE and check latency, result, rd_out and return to idle.
    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] expected;
        bit          special;
        int          cycles;
        expected = refModel(f3, a, b);
        special  = f3[2] && (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        checkOutput({tag, " busy"}, {31'h0, busy}, 32'h1);
        cycles = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " done"}, {31'h0, done}, 32'h1);
        checkOutput({tag, " latency"}, 32'(cycles), special ? 32'd0 : 32'd32);
        checkOutput({tag, " result"}, result, expected);
        checkOutput({tag, " rd_out"}, {27'h0, rd_out}, {27'h0, rd});
        @(negedge clk);
        checkOutput({tag, " idle"}, {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          pulses;
        int          done_seen;
        logic [31:0] seen_result;
        logic [2:0]  f3;

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'h0;
        op_b   = 32'h0;
        rd_in  = 5'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy/done", {30'h0, busy, done}, 32'h0);
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset rd_out", {27'h0, rd_out}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus("MUL 5x10", 3'b000, 32'd5, 32'd10, 5'd7);
        applyStimulus("MULH", 3'b001, 32'hFFFF_FFFF, 32'd3, 5'd1);
        applyStimulus("MULHU", 3'b011, 32'hFFFF_FFFF, 32'd3, 5'd2);
        applyStimulus("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        applyStimulus("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
        applyStimulus("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5);
        applyStimulus("DIVU 10/3", 3'b101, 32'd10, 32'd3, 5'd6);
        applyStimulus("REMU 10/3", 3'b111, 32'd10, 32'd3, 5'd8);
        applyStimulus("DIVU 5/0", 3'b101, 32'd5, 32'd0, 5'd9);
        applyStimulus("REMU 5/0", 3'b111, 32'd5, 32'd0, 5'd10);
        applyStimulus("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        applyStimulus("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        applyStimulus("rd0 MUL", 3'b000, 32'd9, 32'd9, 5'd0);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            applyStimulus($sformatf("rand%0d f3=%0d", i, f3), f3, pickOperand(), pickOperand(),
                          5'($urandom_range(0, 31)));
        end

        // Requests arriving mid-CALC must be dropped.
        funct3 = 3'b000;
        op_a   = 32'd1234;
        op_b   = 32'd5678;
        rd_in  = 5'd13;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        done_seen = 0;
        seen_result = 32'h0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5 || k == 32) begin
                funct3 = 3'b101;
                op_a   = 32'd77;
                op_b   = 32'd0;
                rd_in  = 5'd20;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                done_seen++;
                seen_result = result;
            end
        end
        start = 1'b0;
        checkOutput("ignored start pulses", 32'(done_seen), 32'd1);
        checkOutput("ignored start result", seen_result, refModel(3'b000, 32'd1234, 32'd5678));
        checkOutput("ignored start rd_out", {27'h0, rd_out}, 32'd13);
        checkOutput("ignored start idle", {31'h0, busy}, 32'h0);

        // Asynchronous reset in the middle of a CALC.
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        rd_in  = 5'd14;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("mid reset busy/done", {30'h0, busy, done}, 32'h0);
        checkOutput("mid reset result", result, 32'h0);
        checkOutput("mid reset rd_out", {27'h0, rd_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        countDone(40, pulses);
        checkOutput("mid reset no done", 32'(pulses), 32'd0);

        // Flush during CALC, then flush colliding with start in IDLE.
        applyStimulus("MUL 6x7", 3'b000, 32'd6, 32'd7, 5'd15);
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        rd_in  = 5'd16;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush idle", {31'h0, busy}, 32'h0);
        countDone(40, pulses);
        checkOutput("flush no done", 32'(pulses), 32'd0);
        checkOutput("flush result held", result, 32'd42);
        checkOutput("flush rd_out held", {27'h0, rd_out}, 32'd15);

        funct3 = 3'b000;
        op_a   = 32'd2;
        op_b   = 32'd2;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush beats start", {30'h0, busy, done}, 32'h0);

        applyStimulus("MUL 3x4 after flush", 3'b000, 32'd3, 32'd4, 5'd17);
        checkOutput("MUL 3x4 value", result, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
